// File: rtl/fetch_stage_pkg.sv
// Shared RV32I types for the front end: word/opcode types, fetch FSM states,
// and the bubble instruction.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } fetch_state_t;

    // addi x0, x0, 0
    localparam rv32i_word NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-side memory handshake: a request holds its address until the
// single-cycle response strobe.
interface fetch_stage_if;

    logic        inst_read;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_resp;

    modport master (
        output inst_read,
        output inst_addr,
        input  inst_rdata,
        input  inst_resp
    );

    modport slave (
        input  inst_read,
        input  inst_addr,
        output inst_rdata,
        output inst_resp
    );

endinterface

// File: rtl/fetch_stage_inst_fields.sv
// Purely combinational RV32I field splitter; immediates are sign-extended
// to 32 bits in their architectural bit order.
module inst_fields
    import rv32i_types::*;
(
    input  rv32i_word   inst,
    output rv32i_opcode opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output rv32i_word   i_imm,
    output rv32i_word   s_imm,
    output rv32i_word   b_imm,
    output rv32i_word   u_imm,
    output rv32i_word   j_imm
);

    assign opcode = rv32i_opcode'(inst[6:0]);
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: owns the PC, talks to instruction
// memory, buffers stalled responses and squashes fetches on redirect.
module fetch_stage
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h0000_0060,
    parameter rv32i_word NOP_INST = rv32i_types::NOP_INST
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  rv32i_word            redirect_pc,
    output logic                 valid_o,
    output rv32i_word            pc_o,
    output rv32i_opcode          opcode,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output rv32i_word            i_imm,
    output rv32i_word            s_imm,
    output rv32i_word            b_imm,
    output rv32i_word            u_imm,
    output rv32i_word            j_imm
);

    fetch_state_t state_q, state_d;
    rv32i_word    pc_q, pc_d;
    rv32i_word    tgt_q, tgt_d;
    rv32i_word    hold_q, hold_d;
    rv32i_word    ifid_pc_q, ifid_pc_d;
    rv32i_word    ifid_inst_q, ifid_inst_d;
    logic         ifid_valid_q, ifid_valid_d;

    // A request is outstanding in FETCH and DROP; the address never moves
    // until the response, so DROP keeps presenting the stale pc_q.
    assign imem.inst_read = rst && (state_q != HOLD);
    assign imem.inst_addr = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            hold_q       <= '0;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            hold_q       <= hold_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        hold_d       = hold_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_INST;
                    if (imem.inst_resp) begin
                        pc_d = redirect_pc;
                    end else begin
                        tgt_d   = redirect_pc;
                        state_d = DROP;
                    end
                end else if (imem.inst_resp) begin
                    if (stall) begin
                        hold_d  = imem.inst_rdata;
                        state_d = HOLD;
                    end else begin
                        ifid_pc_d    = pc_q;
                        ifid_inst_d  = imem.inst_rdata;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                    end
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_INST;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_INST;
                    state_d      = FETCH;
                end else if (!stall) begin
                    ifid_pc_d    = pc_q;
                    ifid_inst_d  = hold_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                    state_d      = FETCH;
                end
            end

            DROP: begin
                // Already a bubble since the redirect; keep it that way.
                ifid_valid_d = 1'b0;
                ifid_inst_d  = NOP_INST;
                if (imem.inst_resp) begin
                    pc_d    = redirect ? redirect_pc : tgt_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    tgt_d = redirect_pc;
                end
            end

            default: state_d = FETCH;
        endcase
    end

    assign valid_o = ifid_valid_q;
    assign pc_o    = ifid_pc_q;

    inst_fields u_fields (
        .inst   (ifid_inst_q),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .i_imm  (i_imm),
        .s_imm  (s_imm),
        .b_imm  (b_imm),
        .u_imm  (u_imm),
        .j_imm  (j_imm)
    );

endmodule
